// File: rtl/mul_sequencer.sv
// rtl/mul_sequencer.sv - EX-stage multi-cycle controller: iterative shift-add multiply with pipeline stall
module mul_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [2:0]       ALUCtl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    input  logic [WIDTH-1:0] alu_result_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] result_o,
    output logic             stall_o,
    output logic             done_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0]       ALU_MUL   = 3'b101;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q,    acc_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;

    logic mul_req;

    assign mul_req = start_i && (ALUCtl_i == ALU_MUL) && !flush_i;

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (mul_req) begin
                    mcand_d  = data1_i;
                    mplier_d = data2_i;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_BUSY;
                end
            end
            S_BUSY: begin
                if (flush_i) begin
                    acc_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CNT_ONE;
                    // Fixed latency: never exit early when the multiplier runs out of ones.
                    if (cnt_q == LAST_ITER) begin
                        state_d = S_DONE;
                    end
                end
            end
            // The DONE cycle always returns to IDLE; the still-visible mul in EX is stale.
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        result_o = (state_q == S_IDLE) ? alu_result_i : acc_q;
        stall_o  = 1'b0;
        done_o   = 1'b0;
        if (!rst_i) begin
            case (state_q)
                S_IDLE:  stall_o = mul_req;
                S_BUSY:  stall_o = !flush_i;
                S_DONE:  done_o  = 1'b1;
                default: stall_o = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// tb/tb_mul_sequencer.sv - directed self-checking bench for mul_sequencer
module tb_mul_sequencer;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [2:0]       alu_ctl;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic [WIDTH-1:0] alu_result;
    logic             flush;
    logic [WIDTH-1:0] result;
    logic             stall;
    logic             done;

    int vectors     = 0;
    int miscompares = 0;

    mul_sequencer #(.WIDTH(WIDTH)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .ALUCtl_i     (alu_ctl),
        .data1_i      (data1),
        .data2_i      (data2),
        .alu_result_i (alu_result),
        .flush_i      (flush),
        .result_o     (result),
        .stall_o      (stall),
        .done_o       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nop(input logic [31:0] alu);
        start      = 1'b1;
        alu_ctl    = 3'b011;
        alu_result = alu;
        flush      = 1'b0;
        #1;
    endtask

    task automatic issue_mul(input string tag, input logic [31:0] a, input logic [31:0] b);
        start   = 1'b1;
        alu_ctl = 3'b101;
        data1   = a;
        data2   = b;
        flush   = 1'b0;
        #1;
        check({tag, "_issue_stall"}, 32'(stall), 32'd1);
        check({tag, "_issue_done"}, 32'(done), 32'd0);
    endtask

    // Holds the mul in EX with scrambled operands until done_o; checks latency, stall span and product.
    task automatic wait_done(input string tag, input logic [31:0] exp);
        int n;
        int stalls;
        stalls = 0;
        for (n = 1; n < 100; n++) begin
            tick();
            data1 = $urandom;
            data2 = $urandom;
            #1;
            if (done) break;
            if (stall) stalls++;
        end
        check({tag, "_latency"}, 32'(n), 32'd33);
        check({tag, "_stalls"}, 32'(stalls), 32'd32);
        check({tag, "_result"}, result, exp);
        check({tag, "_done_stall"}, 32'(stall), 32'd0);
    endtask

    // Watches a window of idle cycles for any stray done_o.
    task automatic watch_idle(input string tag, input int cycles);
        int hits;
        hits = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            alu_result = $urandom;
            #1;
            if (done || stall || result !== alu_result) hits++;
        end
        check({tag, "_idle_window"}, 32'(hits), 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b1;
        alu_ctl    = 3'b101;
        data1      = 32'd7;
        data2      = 32'd6;
        alu_result = 32'h0;
        flush      = 1'b0;

        // Reset held two cycles with a mul visible on the inputs.
        #1;
        check("rst0_stall", 32'(stall), 32'd0);
        check("rst0_done", 32'(done), 32'd0);
        tick();
        check("rst1_stall", 32'(stall), 32'd0);
        check("rst1_done", 32'(done), 32'd0);
        tick();
        rst = 1'b0;
        nop(32'h0000_1234);
        check("post_rst_result", result, 32'h0000_1234);
        check("post_rst_stall", 32'(stall), 32'd0);
        check("post_rst_done", 32'(done), 32'd0);
        watch_idle("passthru", 4);

        // Basic multiply, then the DONE cycle with the stale mul still presented.
        tick();
        issue_mul("mul7x6", 32'd7, 32'd6);
        wait_done("mul7x6", 32'h0000_002A);
        tick();
        nop(32'h0000_5555);
        check("after_done_done", 32'(done), 32'd0);
        check("after_done_result", result, 32'h0000_5555);

        tick();
        issue_mul("mulFF", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("mulFF", 32'h0000_0001);
        tick();
        issue_mul("mul80", 32'h8000_0000, 32'd2);
        wait_done("mul80", 32'h0000_0000);
        tick();
        issue_mul("mul0", 32'd0, 32'hDEAD_BEEF);
        wait_done("mul0", 32'h0000_0000);

        // Flush in IDLE blocks the start.
        tick();
        start   = 1'b1;
        alu_ctl = 3'b101;
        flush   = 1'b1;
        alu_result = 32'h0000_0ABC;
        #1;
        check("idle_flush_stall", 32'(stall), 32'd0);
        check("idle_flush_result", result, 32'h0000_0ABC);
        tick();
        nop(32'h0000_0DEF);
        check("idle_flush_next", result, 32'h0000_0DEF);

        // Flush mid-multiply at T+10, then a fresh 3*5.
        tick();
        issue_mul("flushmul", 32'd9, 32'd9);
        for (int i = 0; i < 10; i++) tick();
        flush = 1'b1;
        #1;
        check("flush_stall", 32'(stall), 32'd0);
        check("flush_done", 32'(done), 32'd0);
        tick();
        nop(32'h0);
        watch_idle("flush", 40);
        tick();
        issue_mul("mul3x5", 32'd3, 32'd5);
        wait_done("mul3x5", 32'h0000_000F);

        // Reset at T+5 aborts the multiply.
        tick();
        issue_mul("rstmul", 32'd5, 32'd5);
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        #1;
        check("rst_abort_stall", 32'(stall), 32'd0);
        check("rst_abort_done", 32'(done), 32'd0);
        tick();
        rst = 1'b0;
        nop(32'h0000_0777);
        check("rst_abort_result", result, 32'h0000_0777);
        watch_idle("rst_abort", 40);

        // Back-to-back: second mul enters EX the cycle after DONE.
        tick();
        issue_mul("b2b_a", 32'd2, 32'd3);
        wait_done("b2b_a", 32'h0000_0006);
        tick();
        issue_mul("b2b_b", 32'd4, 32'd5);
        wait_done("b2b_b", 32'h0000_0014);
        tick();
        nop(32'h0000_0042);
        check("b2b_end_done", 32'(done), 32'd0);
        check("b2b_end_stall", 32'(stall), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

- Multi-cycle execution controller for the EX stage.
- Lets the single-cycle ALU handle every operation except multiply (ALUCtl 3'b101).
- Sequences multiply as an iterative shift-add over WIDTH cycles.
- Asserts a stall to the hazard/pipeline-control logic until the product is ready.
- Sits between the ALU control decode, the combinational ALU result and the EX/MEM pipeline register.

## Interface
Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
- clk_i  input  1  clock. All state updates on the rising edge.
- rst_i  input  1  reset. Synchronous, active-high.
- start_i  input  1  a valid instruction occupies EX this cycle.
- ALUCtl_i  input  3  ALU control code from decode; 3'b101 = mul.
- data1_i  input  WIDTH  rs1 operand (multiplicand).
- data2_i  input  WIDTH  rs2 operand (multiplier).
- alu_result_i  input  WIDTH  result of the single-cycle ALU.
- flush_i  input  1  kill the EX instruction (branch/exception).
- result_o  output  WIDTH  EX result to EX/MEM.
- stall_o  output  1  hold PC, IF/ID, ID/EX; EX/MEM takes a bubble.
- done_o  output  1  one-cycle pulse when a multiply result is valid.

## Operation
- Registers:
  - state: IDLE, BUSY, DONE.
  - mcand (WIDTH), mplier (WIDTH), acc (WIDTH).
  - cnt (clog2(WIDTH)+1 bits).
- Request: mul_req = start_i && ALUCtl_i==3'b101 && !flush_i.
- IDLE:
  - result_o = alu_result_i (combinational pass-through); done_o = 0.
  - stall_o = mul_req.
  - If mul_req: latch mcand=data1_i, mplier=data2_i, acc=0, cnt=0; go to BUSY.
  - Otherwise stay in IDLE.
- BUSY, each cycle:
  - If mplier[0], acc = acc + mcand (mod 2^WIDTH).
  - mcand <<= 1; mplier >>= 1; cnt++.
  - When cnt reaches WIDTH-1 this cycle (final iteration), go to DONE.
  - stall_o = 1; result_o = acc.
  - No early termination on mplier==0; latency is fixed.
- DONE:
  - stall_o = 0; done_o = 1; result_o = acc.
  - Unconditionally go to IDLE. Do not restart even though start_i/ALUCtl_i still show the same mul instruction.
- Arithmetic: result is the low WIDTH bits of the product. Identical for signed and unsigned operands; no high half is produced.
- Flush:
  - flush_i in BUSY: stall_o forced 0 that cycle; next state IDLE; acc discarded; no done_o.
  - flush_i in IDLE blocks starting a multiply.
  - flush_i in DONE has no effect on the sequencer; DONE still returns to IDLE.
- Reset:
  - While rst_i is high, stall_o = 0 and done_o = 0.
  - At the edge: state=IDLE; mcand, mplier, acc, cnt = 0.
  - Reset mid-BUSY aborts the multiply with no done_o.
  - After reset: stall_o=0, done_o=0, result_o=alu_result_i.
- Operands are sampled only at the IDLE->BUSY edge. data1_i/data2_i changes during BUSY are ignored.

## Timing
- Non-mul ops: zero added latency, combinational result, no stall.
- Mul entering EX in cycle T:
  - stall_o high in cycles T through T+WIDTH: WIDTH+1 cycles.
  - DONE in cycle T+WIDTH+1: result_o valid, done_o high, stall_o low.
  - EX/MEM captures the product at the end of cycle T+WIDTH+1.
- Back-to-back muls: the second mul is in EX at T+WIDTH+2 and is detected from IDLE that cycle. done_o pulses are WIDTH+2 cycles apart.
- stall_o and done_o are combinational from state and the current-cycle inputs. Downstream must register them; no same-cycle loop may pass through start_i.

## Test plan
- Reset: hold rst_i 2 cycles with start_i=1, ALUCtl_i=101 -> stall_o=0 and done_o=0 throughout; the first post-reset cycle shows IDLE behaviour.
- Pass-through: ALUCtl_i=011, alu_result_i=0x00001234, start_i=1 -> result_o=0x00001234 same cycle, stall_o=0, done_o never asserts.
- Basic mul (WIDTH=32): data1_i=7, data2_i=6 at cycle T -> stall_o high T..T+32, done_o high only at T+33, result_o=0x0000002A.
- Wrap/sign: 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001; 0x80000000*2 -> 0x00000000; 0*0xDEADBEEF -> 0 after the full 33-cycle stall.
- Flush and reset abort:
  - flush_i at T+10 -> stall_o=0 that cycle, no done_o; a subsequent 3*5 -> 0x0000000F.
  - rst_i at T+5 -> stall_o drops, no done_o.
- Back-to-back: mul 2*3, then mul 4*5 in the next EX cycle -> done_o at T+33 (result 6) and T+67 (result 20). The DONE cycle never re-triggers on the stale first instruction.
